// File: rtl/dmem_stage.sv
// Data-memory access stage: byte/half/word loads and stores with WAIT_STATES wait cycles.
// Optional DMEM_MISALIGN_TRAP_EN: flag misaligned requests instead of force-aligning them.
module dmem_stage #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        MemReadIn,
  input  logic        MemWriteIn,
  input  logic [1:0]  MemSizeIn,
  input  logic        MemSignedIn,
  input  logic [31:0] AddressIn,
  input  logic [31:0] WriteDataIn,
  output logic [31:0] ReadDataOut,
  output logic        Stall,
  output logic        MisalignedOut
);

  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} stateType;

  stateType              stateReg, stateNext;
  logic [CNT_W-1:0]      cntReg, cntNext;
  logic [31:0]           memArray [DEPTH];
  logic [ADDR_WIDTH-1:0] wordIdx;
  logic [1:0]            laneOff;
  logic                  isWord, isHalf;
  logic                  misaligned, request, accessNow, writeNow, stallComb;
  logic [3:0]            laneEn;
  logic [31:0]           storeData, wordRd, loadVal;
  logic [15:0]           halfSel;
  logic [7:0]            byteSel;

  assign wordIdx = AddressIn[ADDR_WIDTH+1:2];
  assign isWord  = (MemSizeIn == 2'b00) || (MemSizeIn == 2'b11);
  assign isHalf  = (MemSizeIn == 2'b01);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misaligned = (MemReadIn | MemWriteIn) &
                      ((isHalf & AddressIn[0]) | (isWord & (AddressIn[1:0] != 2'b00)));
  assign laneOff    = AddressIn[1:0];
`else
  // Without the trap, low address bits below the access size are simply dropped.
  assign misaligned = 1'b0;
  assign laneOff    = isWord ? 2'b00 : (isHalf ? {AddressIn[1], 1'b0} : AddressIn[1:0]);
`endif

  assign MisalignedOut = misaligned;
  assign request       = (MemReadIn | MemWriteIn) & ~misaligned;

  always_comb begin
    laneEn    = 4'b1111;
    storeData = WriteDataIn;
    if (isHalf) begin
      laneEn    = laneOff[1] ? 4'b1100 : 4'b0011;
      storeData = {2{WriteDataIn[15:0]}};
    end else if (!isWord) begin
      laneEn    = 4'b0001 << laneOff;
      storeData = {4{WriteDataIn[7:0]}};
    end
  end

  // Reset low must also block the write on the edge it overlaps.
  assign writeNow = accessNow & MemWriteIn & Rst_n;

  always_ff @(posedge Clk) begin
    if (writeNow) begin
      for (int k = 0; k < 4; k++) begin
        if (laneEn[k]) memArray[wordIdx][8*k +: 8] <= storeData[8*k +: 8];
      end
    end
  end

  assign wordRd  = memArray[wordIdx];
  assign halfSel = laneOff[1] ? wordRd[31:16] : wordRd[15:0];
  assign byteSel = wordRd[{laneOff, 3'b000} +: 8];

  always_comb begin
    loadVal = wordRd;
    if (isHalf) begin
      loadVal = {{16{MemSignedIn & halfSel[15]}}, halfSel};
    end else if (!isWord) begin
      loadVal = {{24{MemSignedIn & byteSel[7]}}, byteSel};
    end
  end

  // A combined read+write request only writes, so the load result is held.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ReadDataOut <= 32'h0000_0000;
    end else if (accessNow && MemReadIn && !MemWriteIn) begin
      ReadDataOut <= loadVal;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stateReg <= IDLE;
      cntReg   <= '0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    accessNow = 1'b0;
    stallComb = 1'b0;
    case (stateReg)
      IDLE: begin
        if (request) begin
          stallComb = 1'b1;
          if (WAIT_STATES > 0) begin
            cntNext   = CNT_W'(WAIT_STATES);
            stateNext = WAIT;
          end else begin
            accessNow = 1'b1;
            stateNext = DONE;
          end
        end
      end
      WAIT: begin
        stallComb = 1'b1;
        cntNext   = cntReg - 1'b1;
        if (cntReg == CNT_W'(1)) begin
          accessNow = 1'b1;
          stateNext = DONE;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Held requests must not keep the pipeline frozen while reset is asserted.
  assign Stall = stallComb & Rst_n;

endmodule

// File: tb/tb_dmem_stage.sv
// Randomized self-checking bench for dmem_stage: one instance with 2 wait states, one with 0,
// checked against a byte-addressed reference memory.
module tb_dmem_stage;

  logic        Clk   = 1'b0;
  logic        Rst_n = 1'b1;
  logic        readA = 1'b0, writeA = 1'b0, readB = 1'b0, writeB = 1'b0;
  logic [1:0]  sizeIn   = 2'b00;
  logic        signedIn = 1'b0;
  logic [31:0] addrIn   = '0;
  logic [31:0] wdataIn  = '0;
  logic [31:0] rdOutA, rdOutB;
  logic        stallA, stallB, misA, misB;

  int          testCount = 0;
  int          failCount = 0;
  logic [7:0]  modelMem [int];
  logic [31:0] expRd [2];

  always #5 Clk = ~Clk;

  dmem_stage #(.ADDR_WIDTH(10), .WAIT_STATES(2)) dutA (
    .Clk(Clk), .Rst_n(Rst_n), .MemReadIn(readA), .MemWriteIn(writeA),
    .MemSizeIn(sizeIn), .MemSignedIn(signedIn), .AddressIn(addrIn),
    .WriteDataIn(wdataIn), .ReadDataOut(rdOutA), .Stall(stallA), .MisalignedOut(misA)
  );

  dmem_stage #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dutB (
    .Clk(Clk), .Rst_n(Rst_n), .MemReadIn(readB), .MemWriteIn(writeB),
    .MemSizeIn(sizeIn), .MemSignedIn(signedIn), .AddressIn(addrIn),
    .WriteDataIn(wdataIn), .ReadDataOut(rdOutB), .Stall(stallB), .MisalignedOut(misB)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int accBytes(input logic [1:0] size);
    return (size == 2'd1) ? 2 : ((size == 2'd2) ? 1 : 4);
  endfunction

  function automatic bit modelMis(input logic [1:0] size, input logic [31:0] addr);
`ifdef DMEM_MISALIGN_TRAP_EN
    return (int'(addr[1:0]) % accBytes(size)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  // Memory of 4 KiB per instance; address bits above 11 are ignored.
  function automatic int baseKey(input int sel, input logic [1:0] size, input logic [31:0] addr);
    int n;
    n = accBytes(size);
    return sel * 4096 + (int'(addr[11:0]) / n) * n;
  endfunction

  function automatic logic [31:0] modelLoad(input int sel, input logic [1:0] size,
                                            input bit sgn, input logic [31:0] addr);
    int n, base;
    logic [31:0] v;
    n    = accBytes(size);
    base = baseKey(sel, size, addr);
    v    = '0;
    for (int i = 0; i < n; i++) v = v | (32'(modelMem[base + i]) << (8 * i));
    if (sgn && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
    return v;
  endfunction

  task automatic modelStore(input int sel, input logic [1:0] size,
                            input logic [31:0] addr, input logic [31:0] data);
    int n, base;
    n    = accBytes(size);
    base = baseKey(sel, size, addr);
    for (int i = 0; i < n; i++) modelMem[base + i] = data[8*i +: 8];
  endtask

  task automatic doAccess(input int sel, input bit rd, input bit wr, input logic [1:0] size,
                          input bit sgn, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata);
    bit mis;
    int stallCnt, expStall;
    @(posedge Clk); #1;
    addrIn = addr; wdataIn = wdata; sizeIn = size; signedIn = sgn;
    if (sel == 0) begin readA = rd; writeA = wr; end
    else          begin readB = rd; writeB = wr; end
    mis = modelMis(size, addr) && (rd || wr);
    #1;
    checkVal("misaligned_flag", 32'(sel ? misB : misA), 32'(mis));
    expStall = 0;
    if (!mis && (rd || wr)) begin
      expStall = (sel ? 0 : 2) + 1;
      if (wr) modelStore(sel, size, addr, wdata);
      else    expRd[sel] = modelLoad(sel, size, sgn, addr);
    end
    stallCnt = 0;
    @(negedge Clk);
    while ((sel ? stallB : stallA) && stallCnt < 20) begin
      stallCnt++;
      @(negedge Clk);
    end
    readA = 1'b0; writeA = 1'b0; readB = 1'b0; writeB = 1'b0;
    rdata = sel ? rdOutB : rdOutA;
    checkVal("stall_len", 32'(stallCnt), 32'(expStall));
    checkVal("read_data", rdata, expRd[sel]);
    $display("[TB] dut%0d rd=%0b wr=%0b size=%0d sgn=%0b addr=%h wdata=%h -> rdata=%h stall=%0d",
             sel, rd, wr, size, sgn, addr, wdata, rdata, stallCnt);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    expRd[0] = '0;
    expRd[1] = '0;

    #2 Rst_n = 1'b0;
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    checkVal("reset_rdata_a", rdOutA, 32'h0);
    checkVal("reset_rdata_b", rdOutB, 32'h0);
    checkVal("reset_stall_a", 32'(stallA), 32'h0);
    checkVal("reset_stall_b", 32'(stallB), 32'h0);
    checkVal("reset_mis_a", 32'(misA), 32'h0);

    // Fill the first 80 bytes of both memories so every model read is defined.
    for (int s = 0; s < 2; s++) begin
      for (int w = 0; w < 20; w++) doAccess(s, 0, 1, 2'b00, 0, 32'(4 * w), $urandom, r);
    end

    doAccess(0, 0, 1, 2'b00, 0, 32'h10, 32'hDEADBEEF, r);
    doAccess(0, 1, 0, 2'b00, 0, 32'h10, 32'h0, r);
    checkVal("lw_deadbeef", r, 32'hDEADBEEF);

    doAccess(0, 0, 1, 2'b00, 0, 32'h10, 32'h80AABBCC, r);
    doAccess(0, 1, 0, 2'b10, 1, 32'h13, 32'h0, r);
    checkVal("lb_signed", r, 32'hFFFFFF80);
    doAccess(0, 1, 0, 2'b10, 0, 32'h13, 32'h0, r);
    checkVal("lbu_13", r, 32'h00000080);
    doAccess(0, 1, 0, 2'b10, 0, 32'h10, 32'h0, r);
    checkVal("lbu_10", r, 32'h000000CC);

    doAccess(0, 0, 1, 2'b00, 0, 32'h20, 32'hDEADBEEF, r);
    doAccess(0, 0, 1, 2'b01, 0, 32'h22, 32'h00001234, r);
    doAccess(0, 1, 0, 2'b00, 0, 32'h20, 32'h0, r);
    checkVal("sh_merge", r, 32'h1234BEEF);
    doAccess(0, 0, 1, 2'b10, 0, 32'h21, 32'h00000055, r);
    doAccess(0, 1, 0, 2'b00, 0, 32'h20, 32'h0, r);
    checkVal("sb_merge", r, 32'h123455EF);

    doAccess(0, 1, 0, 2'b00, 0, 32'h11, 32'h0, r);
`ifdef DMEM_MISALIGN_TRAP_EN
    checkVal("mis_hold", r, 32'h123455EF);
    doAccess(0, 1, 0, 2'b00, 0, 32'h10, 32'h0, r);
    checkVal("mis_mem_intact", r, 32'h80AABBCC);
`else
    checkVal("mis_forced", r, 32'h80AABBCC);
`endif

    // Store aborted by reset during the second stall cycle.
    doAccess(0, 0, 1, 2'b00, 0, 32'h30, 32'h0, r);
    @(posedge Clk); #1;
    addrIn = 32'h30; wdataIn = 32'hCAFEF00D; sizeIn = 2'b00; signedIn = 1'b0; writeA = 1'b1;
    @(negedge Clk);
    checkVal("abort_stall_pre", 32'(stallA), 32'h1);
    @(posedge Clk); #1;
    Rst_n = 1'b0;
    #1;
    checkVal("abort_stall", 32'(stallA), 32'h0);
    checkVal("abort_rdata_a", rdOutA, 32'h0);
    checkVal("abort_rdata_b", rdOutB, 32'h0);
    writeA = 1'b0;
    expRd[0] = '0;
    expRd[1] = '0;
    @(negedge Clk);
    Rst_n = 1'b1;
    doAccess(0, 1, 0, 2'b00, 0, 32'h30, 32'h0, r);
    checkVal("abort_no_write", r, 32'h0);

    // Zero wait states: single-cycle stall, read+write performs only the write.
    doAccess(1, 0, 1, 2'b00, 0, 32'h40, 32'h5A5A0F0F, r);
    doAccess(1, 1, 0, 2'b00, 0, 32'h40, 32'h0, r);
    checkVal("ws0_lw", r, 32'h5A5A0F0F);
    doAccess(1, 1, 1, 2'b00, 0, 32'h40, 32'h11112222, r);
    checkVal("ws0_rw_hold", r, 32'h5A5A0F0F);
    doAccess(1, 1, 0, 2'b00, 0, 32'h40, 32'h0, r);
    checkVal("ws0_rw_write", r, 32'h11112222);

    for (int t = 0; t < 120; t++) begin
      int sel, op;
      logic [31:0] addr;
      sel  = int'($urandom_range(0, 1));
      op   = int'($urandom_range(0, 3));
      addr = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 79));
      doAccess(sel, (op != 1), (op == 1 || op == 2), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), addr, $urandom, r);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
